// File: rtl/lc3b_types.sv
// lc3b_types: shared types for the gshare predictor slice.
//   lc3b_word       16-bit LC-3b machine word (used for branch PCs)
//   gshare_entry_t  one in-flight branch record: table index plus the
//                   prediction handed to fetch
//   weak_nt_value   reset value of an N-bit counter (weakly not-taken)
// The index field is sized for the widest legal table so that a single
// struct serves every parameterisation; narrower tables zero-extend.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  localparam int MAX_IDX_BITS = 6;
  localparam int MAX_CTR_BITS = 3;

  typedef struct packed {
    logic [MAX_IDX_BITS-1:0] idx;
    logic                    pred;
  } gshare_entry_t;

  // Largest value whose MSB is still 0, i.e. 2**(ctr_bits-1)-1.
  function automatic logic [MAX_CTR_BITS-1:0] weak_nt_value(input int ctr_bits);
    return MAX_CTR_BITS'((1 << (ctr_bits - 1)) - 1);
  endfunction

endpackage

// File: rtl/pred_fifo.sv
// pred_fifo: parametrised synchronous FIFO holding in-flight branch records.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   push          write push_data at the tail (ignored while full)
//   pop           drop the head entry (ignored while empty)
//   flush         discard every entry; wins over push and pop
//   push_data     entry to append
//   head_data     oldest entry (valid only while !empty)
//   full, empty   occupancy flags
//   count         number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap on their own.
module pred_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; a flush simply rewinds everything.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/gshare_predictor.sv
// gshare_predictor: global-history branch predictor with in-order tracking of
// up to FIFO_DEPTH unresolved branches.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   lookup_valid/pc     fetch presents a branch; PC bits [IDX_BITS:1] index
//   lookup_ready        room in the in-flight FIFO (no bypass on a same-cycle pop)
//   prediction          combinational, MSB of the indexed counter
//   resolve_valid/taken outcome of the oldest in-flight branch
//   resolve_mispredict  combinational, outcome differs from the stored prediction
//   in_flight_count     recorded but unresolved branches
//   stat_branches/stat_mispredicts  present only with GSHARE_STATS_EN defined
// Optional build macro: GSHARE_STATS_EN adds saturating 16-bit statistics.
module gshare_predictor
  import lc3b_types::*;
#(
  parameter int IDX_BITS   = 4,
  parameter int HIST_BITS  = 4,
  parameter int CTR_BITS   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          lookup_valid,
  input  lc3b_word                      lookup_pc,
  output logic                          lookup_ready,
  output logic                          prediction,
  input  logic                          resolve_valid,
  input  logic                          resolve_taken,
  output logic                          resolve_mispredict,
`ifdef GSHARE_STATS_EN
  output logic [15:0]                   stat_branches,
  output logic [15:0]                   stat_mispredicts,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   in_flight_count
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int GW      = (HIST_BITS > 0) ? HIST_BITS : 1;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(weak_nt_value(CTR_BITS));

  logic [GW-1:0]       spec_ghr;
  logic [GW-1:0]       commit_ghr;
  logic [GW-1:0]       commit_next;
  logic [IDX_BITS-1:0] hist_ext;
  logic [IDX_BITS-1:0] lookup_idx;
  logic [IDX_BITS-1:0] upd_idx;
  logic [ENTRIES-1:0]  ctr_msbs;
  gshare_entry_t       push_entry;
  gshare_entry_t       head_entry;
  logic                fifo_full;
  logic                fifo_empty;
  logic                resolve_fire;
  logic                do_push;
  logic                do_pop;
  logic                unused_pc;

  // Shift one outcome into a history register, dropping the oldest bit.
  function automatic logic [GW-1:0] shift_hist(input logic [GW-1:0] h, input logic b);
    logic [GW:0] wide;
    wide = {h, b};
    return wide[GW-1:0];
  endfunction

  // With zero history bits the predictor degenerates to bimodal indexing.
  generate
    if (HIST_BITS > 0) begin : g_hist
      assign hist_ext = IDX_BITS'(spec_ghr);
    end else begin : g_no_hist
      logic unused_ghr;
      assign hist_ext   = '0;
      assign unused_ghr = ^spec_ghr;
    end
  endgenerate

  assign unused_pc  = ^{lookup_pc[15:IDX_BITS+1], lookup_pc[0]};
  assign lookup_idx = lookup_pc[IDX_BITS:1] ^ hist_ext;
  assign prediction = ctr_msbs[lookup_idx];

  assign push_entry.idx  = MAX_IDX_BITS'(lookup_idx);
  assign push_entry.pred = prediction;
  assign upd_idx         = head_entry.idx[IDX_BITS-1:0];

  generate
    if (IDX_BITS < MAX_IDX_BITS) begin : g_idx_pad
      logic unused_idx_pad;
      assign unused_idx_pad = ^head_entry.idx[MAX_IDX_BITS-1:IDX_BITS];
    end
  endgenerate

  assign lookup_ready       = ~fifo_full;
  assign resolve_fire       = resolve_valid & ~fifo_empty;
  assign resolve_mispredict = resolve_fire & (resolve_taken != head_entry.pred);
  // A mispredict flushes wrong-path work, including this cycle's lookup.
  assign do_push            = lookup_valid & lookup_ready & ~resolve_mispredict;
  assign do_pop             = resolve_fire & ~resolve_mispredict;
  assign commit_next        = shift_hist(commit_ghr, resolve_taken);

  pred_fifo #(
    .WIDTH ($bits(gshare_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (do_push),
    .pop       (do_pop),
    .flush     (resolve_mispredict),
    .push_data (push_entry),
    .head_data (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (in_flight_count)
  );

  // Speculative history follows predictions; committed history follows real
  // outcomes and becomes the repair point whenever a mispredict is found.
  always_ff @(posedge clk) begin
    if (rst) begin
      spec_ghr   <= '0;
      commit_ghr <= '0;
    end else begin
      if (resolve_fire) commit_ghr <= commit_next;
      if (resolve_mispredict) spec_ghr <= commit_next;
      else if (do_push)       spec_ghr <= shift_hist(spec_ghr, prediction);
    end
  end

  // Counter table: one saturating counter per entry, trained at the index
  // stored with the resolving branch rather than a recomputed one.
  generate
    for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
      logic [CTR_BITS-1:0] ctr_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          ctr_q <= CTR_INIT;
        end else if (resolve_fire && (upd_idx == IDX_BITS'(i))) begin
          if (resolve_taken) begin
            if (ctr_q != CTR_MAX) ctr_q <= ctr_q + CTR_BITS'(1);
          end else begin
            if (ctr_q != '0) ctr_q <= ctr_q - CTR_BITS'(1);
          end
        end
      end

      assign ctr_msbs[i] = ctr_q[CTR_BITS-1];
    end
  endgenerate

`ifdef GSHARE_STATS_EN
  // Saturating event counters for resolved branches and mispredicts.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (resolve_fire && stat_branches != 16'hFFFF)
        stat_branches <= stat_branches + 16'd1;
      if (resolve_mispredict && stat_mispredicts != 16'hFFFF)
        stat_mispredicts <= stat_mispredicts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gshare_predictor.sv
// tb_gshare_predictor: directed and randomized bench for gshare_predictor at
// default parameters, checked every cycle against a behavioural model.
module tb_gshare_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_valid;
  logic [15:0] lookup_pc;
  logic        lookup_ready;
  logic        prediction;
  logic        resolve_valid;
  logic        resolve_taken;
  logic        resolve_mispredict;
  logic [2:0]  in_flight_count;
`ifdef GSHARE_STATS_EN
  logic [15:0] stat_branches;
  logic [15:0] stat_mispredicts;
`endif

  int checks = 0;
  int errors = 0;

  // Model state: counters as integers, histories as integers, FIFO as queues.
  int m_ctr [16];
  int m_spec;
  int m_commit;
  int m_q_idx  [$];
  int m_q_pred [$];
  int m_stat_br;
  int m_stat_mp;

  gshare_predictor dut (
    .clk                (clk),
    .rst                (rst),
    .lookup_valid       (lookup_valid),
    .lookup_pc          (lookup_pc),
    .lookup_ready       (lookup_ready),
    .prediction         (prediction),
    .resolve_valid      (resolve_valid),
    .resolve_taken      (resolve_taken),
    .resolve_mispredict (resolve_mispredict),
`ifdef GSHARE_STATS_EN
    .stat_branches      (stat_branches),
    .stat_mispredicts   (stat_mispredicts),
`endif
    .in_flight_count    (in_flight_count)
  );

  always #5 clk = ~clk;

  function automatic int modelIndex(input int pc);
    return ((pc >> 1) & 15) ^ (m_spec & 15);
  endfunction

  function automatic int modelPred();
    return (m_ctr[modelIndex(int'(lookup_pc))] >= 2) ? 1 : 0;
  endfunction

  function automatic int modelMispredict();
    if (resolve_valid && m_q_pred.size() > 0 && int'(resolve_taken) != m_q_pred[0]) return 1;
    return 0;
  endfunction

  task automatic modelReset();
    foreach (m_ctr[i]) m_ctr[i] = 1;
    m_spec = 0;
    m_commit = 0;
    m_q_idx.delete();
    m_q_pred.delete();
    m_stat_br = 0;
    m_stat_mp = 0;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic modelStep();
    int mis, fire, accept, idx, pred, h;
    if (rst) begin
      modelReset();
      return;
    end
    mis    = modelMispredict();
    fire   = (resolve_valid && m_q_pred.size() > 0) ? 1 : 0;
    accept = (lookup_valid && m_q_pred.size() < 4 && !mis) ? 1 : 0;
    idx    = modelIndex(int'(lookup_pc));
    pred   = modelPred();
    if (fire) begin
      h = m_q_idx.pop_front();
      void'(m_q_pred.pop_front());
      if (resolve_taken) m_ctr[h] = (m_ctr[h] < 3) ? m_ctr[h] + 1 : 3;
      else               m_ctr[h] = (m_ctr[h] > 0) ? m_ctr[h] - 1 : 0;
      m_commit = ((m_commit << 1) | int'(resolve_taken)) & 15;
      if (m_stat_br < 65535) m_stat_br++;
    end
    if (mis) begin
      m_q_idx.delete();
      m_q_pred.delete();
      m_spec = m_commit;
      if (m_stat_mp < 65535) m_stat_mp++;
    end else if (accept) begin
      m_q_idx.push_back(idx);
      m_q_pred.push_back(pred);
      m_spec = ((m_spec << 1) | pred) & 15;
    end
  endtask

  task automatic compareValue(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare every DUT output with the model for the currently driven inputs.
  task automatic checkOutput();
    compareValue("lookup_ready", int'(lookup_ready), (m_q_pred.size() < 4) ? 1 : 0);
    compareValue("in_flight_count", int'(in_flight_count), m_q_pred.size());
    compareValue("resolve_mispredict", int'(resolve_mispredict), modelMispredict());
    if (lookup_valid) compareValue("prediction", int'(prediction), modelPred());
`ifdef GSHARE_STATS_EN
    compareValue("stat_branches", int'(stat_branches), m_stat_br);
    compareValue("stat_mispredicts", int'(stat_mispredicts), m_stat_mp);
`endif
  endtask

  // Drive one cycle of inputs after the falling edge and check the outputs.
  task automatic applyStimulus(input logic r, input logic lv, input logic [15:0] pc,
                               input logic rv, input logic rt);
    @(negedge clk);
    rst           = r;
    lookup_valid  = lv;
    lookup_pc     = pc;
    resolve_valid = rv;
    resolve_taken = rt;
    #1;
    checkOutput();
  endtask

  task automatic clockEdge();
    @(posedge clk);
    modelStep();
  endtask

  initial begin
    rst = 1'b1; lookup_valid = 1'b0; lookup_pc = '0;
    resolve_valid = 1'b0; resolve_taken = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);

    // Resolve on an empty FIFO is ignored.
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    compareValue("lit reset count", int'(in_flight_count), 0);
    compareValue("lit reset ready", int'(lookup_ready), 1);
    compareValue("lit empty resolve", int'(resolve_mispredict), 0);
    clockEdge();

    // pc 0x0010 -> index 8, counter 1 -> not taken.
    applyStimulus(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0);
    compareValue("lit first pred", int'(prediction), 0);
    clockEdge();

    // Head predicted 0, actual taken -> mispredict, counter 8 becomes 2.
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    compareValue("lit count one", int'(in_flight_count), 1);
    compareValue("lit mispredict", int'(resolve_mispredict), 1);
    clockEdge();

    // History repaired to 0001; pc 0x0012 -> 9 ^ 1 = index 8 -> taken.
    applyStimulus(1'b0, 1'b1, 16'h0012, 1'b0, 1'b0);
    compareValue("lit flushed count", int'(in_flight_count), 0);
    compareValue("lit repaired pred", int'(prediction), 1);
    clockEdge();

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 16'h0020, 1'b0, 1'b0);
      clockEdge();
    end
    applyStimulus(1'b0, 1'b1, 16'h0020, 1'b0, 1'b0);
    compareValue("lit full ready", int'(lookup_ready), 0);
    compareValue("lit full count", int'(in_flight_count), 4);
    clockEdge();
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    compareValue("lit still full", int'(in_flight_count), 4);
    clockEdge();

    // Saturate index 0 downwards with correctly predicted not-taken resolves.
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    clockEdge();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
      clockEdge();
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      compareValue("lit sat no mispredict", int'(resolve_mispredict), 0);
      clockEdge();
    end
    compareValue("lit model sat", m_ctr[0], 0);

    // Reset with two in flight and a concurrent resolve.
    applyStimulus(1'b0, 1'b1, 16'h0004, 1'b0, 1'b0);
    clockEdge();
    applyStimulus(1'b0, 1'b1, 16'h0006, 1'b0, 1'b0);
    clockEdge();
    applyStimulus(1'b1, 1'b1, 16'h0008, 1'b1, 1'b1);
    clockEdge();
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    compareValue("lit post-reset count", int'(in_flight_count), 0);
    compareValue("lit post-reset ready", int'(lookup_ready), 1);
    clockEdge();

    // Randomized traffic against the model; a few PCs to force collisions.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(199) == 0),
                    ($urandom_range(9) < 6),
                    16'($urandom_range(15) << 1),
                    ($urandom_range(9) < 4),
                    1'($urandom_range(1)));
      clockEdge();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
